// File: rtl/onehot_decode_seq.sv
// -----------------------------------------------------------------------------
// onehot_decode_seq
// Receive-side partner of the 8-to-3 priority encoder. Takes a CODE_W-bit
// line index over a valid/ready handshake and drives the matching one-hot
// pattern for HOLD cycles, then GAP all-zero cycles. A one-deep pending
// buffer lets the encoder queue the next code while the current one is
// being driven.
//
// Optional feature macro: DEC_EVENT_CNT_EN
//   When defined, adds evt_cnt: an 8-bit wrapping count of entries into
//   the drive phase.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   in_valid   in   code present (low = no line active)
//   in_code    in   encoded line index
//   in_ready   out  a code can be accepted this cycle (pending buffer empty)
//   out_onehot out  decoded pattern, bit index = code
//   out_valid  out  out_onehot carries a decoded code
//   busy       out  sequencer is not idle
//   evt_cnt    out  drive-entry count (DEC_EVENT_CNT_EN only)
// -----------------------------------------------------------------------------
module onehot_decode_seq #(
    parameter int CODE_W = 3,
    parameter int HOLD   = 4,
    parameter int GAP    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [CODE_W-1:0]        in_code,
    output logic                     in_ready,
    output logic [(2**CODE_W)-1:0]   out_onehot,
    output logic                     out_valid,
    output logic                     busy
`ifdef DEC_EVENT_CNT_EN
    ,
    output logic [7:0]               evt_cnt
`endif
);

    localparam int OUT_W = 2**CODE_W;
    localparam int HCW   = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int GCW   = (GAP > 1) ? $clog2(GAP) : 1;

    // Counters load with N-1 so the phase lasts exactly N cycles.
    localparam logic [HCW-1:0] HOLD_LOAD = HCW'(HOLD - 1);
    localparam logic [GCW-1:0] GAP_LOAD  = GCW'((GAP > 0) ? (GAP - 1) : 0);
    localparam logic [HCW-1:0] HOLD_ONE  = HCW'(1'b1);
    localparam logic [GCW-1:0] GAP_ONE   = GCW'(1'b1);
    localparam logic [HCW-1:0] HOLD_ZERO = {HCW{1'b0}};
    localparam logic [GCW-1:0] GAP_ZERO  = {GCW{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    function automatic logic [OUT_W-1:0] decode_onehot(input logic [CODE_W-1:0] code);
        decode_onehot = {{(OUT_W-1){1'b0}}, 1'b1} << code;
    endfunction

    state_t              state_r, state_nxt_s;
    logic [HCW-1:0]      hold_cnt_r, hold_nxt_s;
    logic [GCW-1:0]      gap_cnt_r, gap_nxt_s;
    logic                pend_valid_r, pend_valid_nxt_s;
    logic [CODE_W-1:0]   pend_code_r, pend_code_nxt_s;
    logic [CODE_W-1:0]   cur_code_r, cur_code_nxt_s;
    logic [OUT_W-1:0]    out_onehot_r, onehot_nxt_s;
    logic                out_valid_r, valid_nxt_s;
    logic                busy_r, busy_nxt_s;
    logic                accept_s;

    // Ready depends only on the pending flag, so reset raises it at once.
    assign in_ready = ~pend_valid_r;
    assign accept_s = in_valid & ~pend_valid_r;

    assign out_onehot = out_onehot_r;
    assign out_valid  = out_valid_r;
    assign busy       = busy_r;

    // State, counters, pending buffer and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            hold_cnt_r   <= HOLD_ZERO;
            gap_cnt_r    <= GAP_ZERO;
            pend_valid_r <= 1'b0;
            pend_code_r  <= {CODE_W{1'b0}};
            cur_code_r   <= {CODE_W{1'b0}};
            out_onehot_r <= {OUT_W{1'b0}};
            out_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            hold_cnt_r   <= hold_nxt_s;
            gap_cnt_r    <= gap_nxt_s;
            pend_valid_r <= pend_valid_nxt_s;
            pend_code_r  <= pend_code_nxt_s;
            cur_code_r   <= cur_code_nxt_s;
            out_onehot_r <= onehot_nxt_s;
            out_valid_r  <= valid_nxt_s;
            busy_r       <= busy_nxt_s;
        end
    end

    // Next-state, counter and pending-buffer logic.
    always_comb begin
        state_nxt_s      = state_r;
        hold_nxt_s       = hold_cnt_r;
        gap_nxt_s        = gap_cnt_r;
        pend_valid_nxt_s = pend_valid_r;
        pend_code_nxt_s  = pend_code_r;
        cur_code_nxt_s   = cur_code_r;

        // Accept and consume are mutually exclusive: accept needs the buffer
        // empty, consume needs it full. Outside IDLE an accept always queues.
        if (accept_s && (state_r != ST_IDLE)) begin
            pend_valid_nxt_s = 1'b1;
            pend_code_nxt_s  = in_code;
        end else begin
            pend_code_nxt_s  = pend_code_r;
        end

        case (state_r)
            ST_IDLE: begin
                // A code queued on the cycle the FSM fell back to IDLE wins.
                if (pend_valid_r) begin
                    state_nxt_s      = ST_DRIVE;
                    cur_code_nxt_s   = pend_code_r;
                    hold_nxt_s       = HOLD_LOAD;
                    pend_valid_nxt_s = 1'b0;
                end else if (accept_s) begin
                    state_nxt_s    = ST_DRIVE;
                    cur_code_nxt_s = in_code;
                    hold_nxt_s     = HOLD_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (hold_cnt_r != HOLD_ZERO) begin
                    hold_nxt_s = hold_cnt_r - HOLD_ONE;
                end else if (GAP > 0) begin
                    state_nxt_s = ST_GAP;
                    gap_nxt_s   = GAP_LOAD;
                end else if (pend_valid_r) begin
                    // Back-to-back reload with no zero cycle in between.
                    state_nxt_s      = ST_DRIVE;
                    cur_code_nxt_s   = pend_code_r;
                    hold_nxt_s       = HOLD_LOAD;
                    pend_valid_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r != GAP_ZERO) begin
                    gap_nxt_s = gap_cnt_r - GAP_ONE;
                end else if (pend_valid_r) begin
                    state_nxt_s      = ST_DRIVE;
                    cur_code_nxt_s   = pend_code_r;
                    hold_nxt_s       = HOLD_LOAD;
                    pend_valid_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so outputs leave a register.
    always_comb begin
        onehot_nxt_s = {OUT_W{1'b0}};
        valid_nxt_s  = 1'b0;
        busy_nxt_s   = (state_nxt_s != ST_IDLE);
        if (state_nxt_s == ST_DRIVE) begin
            onehot_nxt_s = decode_onehot(cur_code_nxt_s);
            valid_nxt_s  = 1'b1;
        end else begin
            onehot_nxt_s = {OUT_W{1'b0}};
            valid_nxt_s  = 1'b0;
        end
    end

`ifdef DEC_EVENT_CNT_EN
    logic [7:0] evt_cnt_r;
    logic       enter_drive_s;

    // Entry into DRIVE: from IDLE/GAP, or a reload at the end of a hold.
    assign enter_drive_s = (state_nxt_s == ST_DRIVE) &&
                           !((state_r == ST_DRIVE) && (hold_cnt_r != HOLD_ZERO));
    assign evt_cnt = evt_cnt_r;

    // Wrapping drive-entry counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_cnt_r <= 8'd0;
        end else if (enter_drive_s) begin
            evt_cnt_r <= evt_cnt_r + 8'd1;
        end else begin
            evt_cnt_r <= evt_cnt_r;
        end
    end
`endif

endmodule

// File: tb/tb_onehot_decode_seq.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for onehot_decode_seq.
// u_dut : default HOLD=4, GAP=1.   u_fast : HOLD=1, GAP=0.
// -----------------------------------------------------------------------------
module tb_onehot_decode_seq;

    logic       clk;
    logic       rst_s;
    logic       in_valid_s;
    logic [2:0] in_code_s;
    logic       in_ready_s;
    logic [7:0] out_onehot_s;
    logic       out_valid_s;
    logic       busy_s;

    logic       f_rst_s;
    logic       f_valid_s;
    logic [2:0] f_code_s;
    logic       f_ready_s;
    logic [7:0] f_onehot_s;
    logic       f_out_valid_s;
    logic       f_busy_s;
`ifdef DEC_EVENT_CNT_EN
    logic [7:0] evt_cnt_s;
    logic [7:0] f_evt_cnt_s;
`endif

    int errors;
    int checks;

    logic [2:0] codes_a [8];
    logic [7:0] exp_d   [16];
    logic       exp_r   [16];
    logic       exp_b   [16];

    onehot_decode_seq u_dut (
        .clk        (clk),
        .rst        (rst_s),
        .in_valid   (in_valid_s),
        .in_code    (in_code_s),
        .in_ready   (in_ready_s),
        .out_onehot (out_onehot_s),
        .out_valid  (out_valid_s),
        .busy       (busy_s)
`ifdef DEC_EVENT_CNT_EN
        ,
        .evt_cnt    (evt_cnt_s)
`endif
    );

    onehot_decode_seq #(.CODE_W(3), .HOLD(1), .GAP(0)) u_fast (
        .clk        (clk),
        .rst        (f_rst_s),
        .in_valid   (f_valid_s),
        .in_code    (f_code_s),
        .in_ready   (f_ready_s),
        .out_onehot (f_onehot_s),
        .out_valid  (f_out_valid_s),
        .busy       (f_busy_s)
`ifdef DEC_EVENT_CNT_EN
        ,
        .evt_cnt    (f_evt_cnt_s)
`endif
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer codes_a[0..ncodes-1] on u_dut, advancing on each handshake, and
    // compare outputs after every edge against exp_d / exp_r / exp_b.
    task automatic play(input string name, input int ncodes, input int ncyc);
        int   idx;
        logic acc;
        idx = 0;
        for (int k = 0; k < ncyc; k++) begin
            if (idx < ncodes) begin
                in_valid_s = 1'b1;
                in_code_s  = codes_a[idx];
            end else begin
                in_valid_s = 1'b0;
            end
            acc = in_valid_s & in_ready_s;
            step();
            if (acc) idx++;
            check($sformatf("%s_onehot_c%0d", name, k), {24'd0, out_onehot_s}, {24'd0, exp_d[k]});
            check($sformatf("%s_valid_c%0d", name, k), {31'd0, out_valid_s}, {31'd0, (exp_d[k] != 8'h00)});
            check($sformatf("%s_ready_c%0d", name, k), {31'd0, in_ready_s}, {31'd0, exp_r[k]});
            check($sformatf("%s_busy_c%0d", name, k), {31'd0, busy_s}, {31'd0, exp_b[k]});
        end
        in_valid_s = 1'b0;
        check($sformatf("%s_accepts", name), idx, ncodes);
    endtask

    initial begin
        int         idx;
        logic       acc;
        logic [7:0] exp_oh;

        errors     = 0;
        checks     = 0;
        rst_s      = 1'b1;
        f_rst_s    = 1'b1;
        in_valid_s = 1'b0;
        in_code_s  = 3'd0;
        f_valid_s  = 1'b0;
        f_code_s   = 3'd0;

        // Reset state, observed while reset is held.
        #3;
        check("rst_onehot", {24'd0, out_onehot_s}, 32'h0);
        check("rst_valid",  {31'd0, out_valid_s}, 32'd0);
        check("rst_busy",   {31'd0, busy_s}, 32'd0);
        check("rst_ready",  {31'd0, in_ready_s}, 32'd1);
        step();
        rst_s   = 1'b0;
        f_rst_s = 1'b0;
        step();
        check("idle_ready", {31'd0, in_ready_s}, 32'd1);
        check("idle_busy",  {31'd0, busy_s}, 32'd0);

        // Single code 5: 4 cycles of 0x20, one gap cycle, then idle.
        codes_a = '{3'd5, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        exp_d   = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00,
                    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_r   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                    1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        exp_b   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        play("single5", 1, 6);
        step();

        // Code 0 then 7: 7 waits in pending, ready low until consumed.
        codes_a = '{3'd0, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        exp_d   = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h80, 8'h80, 8'h80,
                    8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_r   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                    1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        exp_b   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        play("pend07", 2, 11);
        step();

        // Codes 2,3,4 with valid held: 4 stalls until 3 leaves pending.
        codes_a = '{3'd2, 3'd3, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        exp_d   = '{8'h04, 8'h04, 8'h04, 8'h04, 8'h00, 8'h08, 8'h08, 8'h08,
                    8'h08, 8'h00, 8'h10, 8'h10, 8'h10, 8'h10, 8'h00, 8'h00};
        exp_r   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                    1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        exp_b   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                    1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        play("b2b234", 3, 16);
        step();

        // Reset in the 2nd drive cycle of code 6 with code 1 pending.
        in_valid_s = 1'b1;
        in_code_s  = 3'd6;
        step();
        in_code_s  = 3'd1;
        step();
        in_valid_s = 1'b0;
        check("mid_onehot", {24'd0, out_onehot_s}, 32'h40);
        check("mid_ready",  {31'd0, in_ready_s}, 32'd0);
        rst_s = 1'b1;
        #1;
        check("async_onehot", {24'd0, out_onehot_s}, 32'h0);
        check("async_valid",  {31'd0, out_valid_s}, 32'd0);
        check("async_ready",  {31'd0, in_ready_s}, 32'd1);
        check("async_busy",   {31'd0, busy_s}, 32'd0);
        #2;
        rst_s = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("postrst_onehot_c%0d", k), {24'd0, out_onehot_s}, 32'h0);
            check($sformatf("postrst_busy_c%0d", k),   {31'd0, busy_s}, 32'd0);
        end

        // HOLD=1, GAP=0 sweep 0..7 with valid held: each queued code is
        // consumed from IDLE, so patterns alternate with a zero cycle.
        idx = 0;
        for (int k = 0; k < 16; k++) begin
            f_valid_s = (idx < 8);
            f_code_s  = idx[2:0];
            acc = f_valid_s & f_ready_s;
            step();
            if (acc) idx++;
            exp_oh = 8'h01;
            exp_oh = ((k % 2) == 0) ? (exp_oh << (k / 2)) : 8'h00;
            check($sformatf("sweep_onehot_c%0d", k), {24'd0, f_onehot_s}, {24'd0, exp_oh});
            check($sformatf("sweep_oh0_c%0d", k), {31'd0, $onehot0(f_onehot_s)}, 32'd1);
            check($sformatf("sweep_busy_c%0d", k), {31'd0, f_busy_s}, {31'd0, ((k % 2) == 0)});
            check($sformatf("sweep_ready_c%0d", k), {31'd0, f_ready_s},
                  {31'd0, !(((k % 2) == 1) && (k < 15))});
        end
        f_valid_s = 1'b0;
        check("sweep_accepts", idx, 8);

`ifdef DEC_EVENT_CNT_EN
        // 258 accepted codes on a freshly reset instance -> counter wraps to 2.
        f_rst_s = 1'b1;
        #1;
        check("evt_rst", {24'd0, f_evt_cnt_s}, 32'd0);
        f_rst_s = 1'b0;
        idx = 0;
        for (int k = 0; (k < 2000) && (idx < 258); k++) begin
            f_valid_s = 1'b1;
            f_code_s  = idx[2:0];
            acc = f_valid_s & f_ready_s;
            step();
            if (acc) idx++;
        end
        f_valid_s = 1'b0;
        check("evt_accepts", idx, 258);
        for (int k = 0; (k < 20) && (f_busy_s || !f_ready_s); k++) begin
            step();
        end
        check("evt_drained", {31'd0, f_busy_s}, 32'd0);
        check("evt_cnt", {24'd0, f_evt_cnt_s}, 32'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
